// File: rtl/cpu_pkg.sv
// Shared RV32I core types plus the data-memory responder state and
// request-decode helpers.
package cpu_pkg;

  typedef enum logic [2:0] {
    LOAD_DISABLE = 3'b000,
    LOAD_LB      = 3'b001,
    LOAD_LH      = 3'b010,
    LOAD_LW      = 3'b011,
    LOAD_LBU     = 3'b101,
    LOAD_LHU     = 3'b110
  } load_type_t;

  typedef enum logic [1:0] {
    STORE_DISABLE = 2'b00,
    STORE_SB      = 2'b01,
    STORE_SH      = 2'b10,
    STORE_SW      = 2'b11
  } store_type_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT   = 2'b01,
    ACCESS = 2'b10,
    RESP   = 2'b11
  } dmem_state_t;

  // 3'b100 and 3'b111 are unused load encodings.
  function automatic logic is_illegal(input logic [2:0] load, input logic [1:0] store);
    logic ld_on;
    logic st_on;
    ld_on = (load != LOAD_DISABLE);
    st_on = (store != STORE_DISABLE);
    is_illegal = (ld_on && st_on) || (!ld_on && !st_on) ||
                 (load == 3'b100) || (load == 3'b111);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] load, input logic [1:0] store,
                                         input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (load)
      LOAD_LH, LOAD_LHU: mis = off[0];
      LOAD_LW:           mis = (off != 2'b00);
      default:           mis = 1'b0;
    endcase
    case (store)
      STORE_SH: mis = mis | off[0];
      STORE_SW: mis = mis | (off != 2'b00);
      default:  mis = mis;
    endcase
    is_misaligned = mis;
  endfunction

  function automatic logic [3:0] byte_enable(input logic [1:0] store, input logic [1:0] off);
    logic [3:0] be;
    case (store)
      STORE_SB: be = 4'b0001 << off;
      STORE_SH: be = off[1] ? 4'b1100 : 4'b0011;
      STORE_SW: be = 4'b1111;
      default:  be = 4'b0000;
    endcase
    byte_enable = be;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] load, input logic [31:0] word,
                                              input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (load)
      LOAD_LB:  r = {{24{b[7]}}, b};
      LOAD_LBU: r = {24'h000000, b};
      LOAD_LH:  r = {{16{h[15]}}, h};
      LOAD_LHU: r = {16'h0000, h};
      LOAD_LW:  r = word;
      default:  r = 32'h0000_0000;
    endcase
    load_extend = r;
  endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Single-port synchronous word RAM with per-byte write enables and a
// registered read port (read returns the pre-write contents).
module dmem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Byte-lane write and registered read; contents are never reset.
  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int i = 0; i < 4; i++) begin
        if (we_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's load/store port: one request at a
// time, optional wait states, registered response held until accepted.
module dmem_responder
  import cpu_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_load,
  input  logic [1:0]  req_store,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH);

  dmem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  load_q;
  logic [1:0]  store_q;
  logic        resp_valid_q, resp_err_q;
  logic [31:0] resp_rdata_q;

  logic        accept_s, resp_done_s, capture_s, err_s, oor_s, ram_en_s;
  logic [3:0]  ram_we_s;
  logic [31:0] wdata_lane_s, ram_rdata_s;

  assign accept_s    = (state_q == IDLE) && req_valid;
  assign resp_done_s = (state_q == RESP) && resp_valid_q && resp_ready;
  // First RESP cycle: the array's registered read is now valid.
  assign capture_s   = (state_q == RESP) && !resp_valid_q;

  assign oor_s = ({2'b00, addr_q[31:2]} >= 32'(DEPTH));
  assign err_s = is_illegal(load_q, store_q) ||
                 is_misaligned(load_q, store_q, addr_q[1:0]) || oor_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
          cnt_d   = 4'(WAIT_CYCLES - 1);
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        if (resp_valid_q && resp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the state register.
  always_comb begin
    req_ready = (state_q == IDLE);
  end

  // Wait counter and latched request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      load_q  <= 3'b000;
      store_q <= 2'b00;
    end else begin
      cnt_q <= cnt_d;
      if (accept_s) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        load_q  <= req_load;
        store_q <= req_store;
      end
    end
  end

  // Replicate store data so every enabled lane sees its own bytes.
  always_comb begin
    case (store_q)
      STORE_SB: wdata_lane_s = {4{wdata_q[7:0]}};
      STORE_SH: wdata_lane_s = {2{wdata_q[15:0]}};
      default:  wdata_lane_s = wdata_q;
    endcase
  end

  assign ram_en_s = (state_q == ACCESS);
  assign ram_we_s = (ram_en_s && !err_s) ? byte_enable(store_q, addr_q[1:0]) : 4'b0000;

  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk    (clk),
    .en_i   (ram_en_s),
    .we_i   (ram_we_s),
    .addr_i (addr_q[AW+1:2]),
    .wdata_i(wdata_lane_s),
    .rdata_o(ram_rdata_s)
  );

  // Response registers: loaded once on RESP entry, cleared on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
      resp_err_q   <= 1'b0;
    end else if (capture_s) begin
      resp_valid_q <= 1'b1;
      resp_err_q   <= err_s;
      resp_rdata_q <= err_s ? 32'h0000_0000 : load_extend(load_q, ram_rdata_s, addr_q[1:0]);
    end else if (resp_done_s) begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_q;
      resp_rdata_q <= resp_rdata_q;
      resp_err_q   <= resp_err_q;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: instance 0 has no wait states, instance 1 has three.
module tb_dmem_responder;
  import cpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] req_addr [2];
  logic [2:0]  req_load [2];
  logic [1:0]  req_store [2];
  logic [31:0] req_wdata [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err [2];

  int n_err = 0;
  int n_chk = 0;

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .req_load(req_load[0]), .req_store(req_store[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .req_load(req_load[1]), .req_store(req_store[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_outputs(input int d, input string tag);
    chk({tag, ":req_ready"},  32'(req_ready[d]),  32'd1);
    chk({tag, ":resp_valid"}, 32'(resp_valid[d]), 32'd0);
    chk({tag, ":resp_rdata"}, resp_rdata[d],      32'h0000_0000);
    chk({tag, ":resp_err"},   32'(resp_err[d]),   32'd0);
  endtask

  // One full request/response; hold = cycles resp_ready stays low after resp_valid.
  task automatic xact(input int d, input string tag, input logic [31:0] a,
                      input logic [2:0] ld, input logic [1:0] st, input logic [31:0] wd,
                      input int hold, input int exp_lat,
                      input logic [31:0] exp_rd, input logic exp_er);
    int lat;
    @(negedge clk);
    chk({tag, ":ready_before"}, 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_addr[d]  = a;
    req_load[d]  = ld;
    req_store[d] = st;
    req_wdata[d] = wd;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    req_load[d]  = LOAD_DISABLE;
    req_store[d] = STORE_DISABLE;
    lat = 0;
    while (resp_valid[d] !== 1'b1 && lat < 40) begin
      chk({tag, ":ready_busy"}, 32'(req_ready[d]), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ":latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ":rdata"}, resp_rdata[d], exp_rd);
    chk({tag, ":err"}, 32'(resp_err[d]), 32'(exp_er));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, ":hold_valid"}, 32'(resp_valid[d]), 32'd1);
      chk({tag, ":hold_rdata"}, resp_rdata[d], exp_rd);
      chk({tag, ":hold_ready"}, 32'(req_ready[d]), 32'd0);
    end
    @(negedge clk);
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    resp_ready[d] = 1'b0;
    chk({tag, ":valid_after"}, 32'(resp_valid[d]), 32'd0);
    chk({tag, ":ready_after"}, 32'(req_ready[d]), 32'd1);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d]  = 1'b0;
      req_addr[d]   = 32'h0000_0000;
      req_load[d]   = LOAD_DISABLE;
      req_store[d]  = STORE_DISABLE;
      req_wdata[d]  = 32'h0000_0000;
      resp_ready[d] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs(0, "reset0");
    chk_idle_outputs(1, "reset1");
    @(negedge clk);
    rst_n = 1'b1;

    // No wait states: stores, loads with extension, lane merges
    xact(0, "sw_dead",  32'h10, LOAD_DISABLE, STORE_SW, 32'hDEADBEEF, 0, 2, 32'h0, 1'b0);
    xact(0, "lw_dead",  32'h10, LOAD_LW,  STORE_DISABLE, 32'h0, 0, 2, 32'hDEADBEEF, 1'b0);
    xact(0, "lb_13",    32'h13, LOAD_LB,  STORE_DISABLE, 32'h0, 0, 2, 32'hFFFFFFDE, 1'b0);
    xact(0, "lbu_13",   32'h13, LOAD_LBU, STORE_DISABLE, 32'h0, 0, 2, 32'h000000DE, 1'b0);
    xact(0, "lh_12",    32'h12, LOAD_LH,  STORE_DISABLE, 32'h0, 0, 2, 32'hFFFFDEAD, 1'b0);
    xact(0, "lhu_10",   32'h10, LOAD_LHU, STORE_DISABLE, 32'h0, 0, 2, 32'h0000BEEF, 1'b0);
    xact(0, "lb_10",    32'h10, LOAD_LB,  STORE_DISABLE, 32'h0, 0, 2, 32'hFFFFFFEF, 1'b0);
    xact(0, "sb_11",    32'h11, LOAD_DISABLE, STORE_SB, 32'hAAAAAA55, 0, 2, 32'h0, 1'b0);
    xact(0, "lw_sb",    32'h10, LOAD_LW,  STORE_DISABLE, 32'h0, 0, 2, 32'hDEAD55EF, 1'b0);
    xact(0, "sh_12",    32'h12, LOAD_DISABLE, STORE_SH, 32'hBBBB1234, 0, 2, 32'h0, 1'b0);
    xact(0, "lw_sh",    32'h10, LOAD_LW,  STORE_DISABLE, 32'h0, 0, 2, 32'h123455EF, 1'b0);
    xact(0, "lh_10pos", 32'h10, LOAD_LH,  STORE_DISABLE, 32'h0, 0, 2, 32'h000055EF, 1'b0);

    // Error cases: no write, rdata 0, same timing
    xact(0, "err_sh11",  32'h11,   LOAD_DISABLE, STORE_SH, 32'hFFFFFFFF, 0, 2, 32'h0, 1'b1);
    xact(0, "err_lw12",  32'h12,   LOAD_LW, STORE_DISABLE, 32'h0, 0, 2, 32'h0, 1'b1);
    xact(0, "err_oor",   32'h1000, LOAD_LW, STORE_DISABLE, 32'h0, 0, 2, 32'h0, 1'b1);
    xact(0, "err_both",  32'h10,   LOAD_LW, STORE_SW, 32'h00000000, 0, 2, 32'h0, 1'b1);
    xact(0, "err_none",  32'h10,   LOAD_DISABLE, STORE_DISABLE, 32'h0, 0, 2, 32'h0, 1'b1);
    xact(0, "err_ld100", 32'h10,   3'b100, STORE_DISABLE, 32'h0, 0, 2, 32'h0, 1'b1);
    xact(0, "err_sw_oor", 32'h1000, LOAD_DISABLE, STORE_SW, 32'h0, 0, 2, 32'h0, 1'b1);
    xact(0, "last_word", 32'hFFC,  LOAD_DISABLE, STORE_SW, 32'h01020304, 0, 2, 32'h0, 1'b0);
    xact(0, "lw_last",   32'hFFC,  LOAD_LW, STORE_DISABLE, 32'h0, 0, 2, 32'h01020304, 1'b0);
    xact(0, "lw_kept",   32'h10,   LOAD_LW, STORE_DISABLE, 32'h0, 0, 2, 32'h123455EF, 1'b0);

    // Three wait states: latency 5, response held under back-pressure
    xact(1, "w_sw",   32'h10, LOAD_DISABLE, STORE_SW, 32'hCAFEF00D, 0, 5, 32'h0, 1'b0);
    xact(1, "w_lw",   32'h10, LOAD_LW, STORE_DISABLE, 32'h0, 4, 5, 32'hCAFEF00D, 1'b0);
    xact(1, "w_sw20", 32'h20, LOAD_DISABLE, STORE_SW, 32'h11111111, 0, 5, 32'h0, 1'b0);

    // Reset while in WAIT abandons the store
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_addr[1]  = 32'h20;
    req_store[1] = STORE_SW;
    req_wdata[1] = 32'hFFFFFFFF;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    req_store[1] = STORE_DISABLE;
    chk("abort:in_wait_ready", 32'(req_ready[1]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs(1, "abort_rst1");
    chk_idle_outputs(0, "abort_rst0");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("abort:no_resp", 32'(resp_valid[1]), 32'd0);
    end
    xact(1, "w_lw20", 32'h20, LOAD_LW, STORE_DISABLE, 32'h0, 0, 5, 32'h11111111, 1'b0);

    // Reset while a response is pending drops resp_valid at once
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h10;
    req_load[0]  = LOAD_LW;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    req_load[0]  = LOAD_DISABLE;
    repeat (2) @(posedge clk);
    #1;
    chk("resp_rst:valid_before", 32'(resp_valid[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs(0, "resp_rst");
    @(negedge clk);
    rst_n = 1'b1;
    xact(0, "post_rst", 32'h10, LOAD_LW, STORE_DISABLE, 32'h0, 0, 2, 32'h123455EF, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the RV32I 2-stage core: the memory-side end of the core's load/store request interface.
- Accepts one request at a time under a valid/ready handshake, decoded as load_type_t / store_type_t.
- Performs byte-lane writes, and reads with sign or zero extension, on an internal word-addressed synchronous RAM.
- Returns one response per accepted request; a programmable wait-state counter models slow memory.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array (power of two).
- WAIT_CYCLES, 0, extra stall cycles inserted between acceptance and array access (0..15).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  byte address.
- req_load  in  3  load_type_t.
- req_store  in  2  store_type_t.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  core accepts the response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range or illegal request.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - Acceptance occurs at the edge where req_valid&&req_ready.
  - Addr, types and wdata are latched at that edge.
  - Next state is WAIT if WAIT_CYCLES>0, else ACCESS.
- WAIT:
  - req_ready=0.
  - Counter loads WAIT_CYCLES-1 on entry and decrements each cycle.
  - Go to ACCESS when the counter equals 0.
- ACCESS:
  - req_ready=0.
  - The RAM operation happens at this state's closing edge.
  - Next state is RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable.
  - On resp_valid&&resp_ready, go to IDLE; resp_valid drops at that edge.
- Latency: resp_valid rises exactly 2+WAIT_CYCLES edges after the acceptance edge. There is no back-to-back overlap; req_ready is low from acceptance until the response handshake.
- Error checks, evaluated on the latched request:
  - Illegal: load!=LOAD_DISABLE and store!=STORE_DISABLE simultaneously.
  - Illegal: both types DISABLE.
  - Illegal: load encodings 3'b100 or 3'b111.
  - Misaligned: LH/LHU/SH with addr[0]=1.
  - Misaligned: LW/SW with addr[1:0]!=0.
  - Out of range: word index addr[31:2] >= DEPTH.
  - On any error: no RAM write, resp_err=1, resp_rdata=0. The FSM follows the same timing as a normal access.
- Stores (little-endian):
  - SB writes lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all four lanes.
  - Unwritten lanes are unchanged.
- Loads:
  - The word is read at the ACCESS edge.
  - LB/LBU select byte addr[1:0].
  - LH/LHU select halfword addr[1].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
  - LW returns the full word.
- Reset mid-operation:
  - Asserting rst_n=0 in WAIT or ACCESS before the ACCESS edge abandons the request: no write and no response.
  - Asserting rst_n=0 in RESP drops resp_valid immediately.
- resp_ready held high in IDLE/WAIT/ACCESS has no effect.
- req_valid while req_ready=0 is ignored; the core must hold its request.

Decomposition:
- Shared package cpu_pkg gains:
  - dmem_state_t (IDLE, WAIT, ACCESS, RESP).
  - Helper functions is_misaligned(load, store, addr[1:0]) and byte_enable(store, addr[1:0]) returning 4 bits.
- Existing load_type_t and store_type_t are reused unchanged.
- One sub-module, dmem_array: single-port synchronous RAM, DEPTH x 32, per-byte write enables, one-cycle registered read.

Test Plan:
- SW 0xDEADBEEF to 0x10, then LW 0x10, WAIT_CYCLES=0 -> each resp_valid 2 edges after acceptance; LW returns 0xDEADBEEF, err=0.
- After that word: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
- SB 0x55 to 0x11 over the word, then LW 0x10 -> 0xDEAD55EF. SH 0x1234 to 0x12, then LW -> 0x123455EF.
- Errors: SH to 0x11, LW to 0x12, LW to DEPTH*4, and load+store both set -> each gives resp_err=1, rdata=0. A following LW 0x10 is unchanged at 0x123455EF.
- WAIT_CYCLES=3, LW 0x10, resp_ready low for 4 cycles -> resp_valid at edge 5 after acceptance, held with stable data; req_ready=0 until the response handshake, then 1.
- Start SW 0xFFFFFFFF to 0x20 with WAIT_CYCLES=3 and pulse rst_n low during WAIT -> no response; a later LW 0x20 returns the prior contents; all outputs at reset values during reset.
